// File: rtl/bram_tdp_pipelined.sv
// True-dual-port RAM: per-lane write enables, per-port read-during-write mode, clear sequencer, collision flag.
// Read data/valid READ_LATENCY cycles after an accepted access, one per cycle per port; no backpressure, requests dropped while busy.
module bram_tdp_pipelined #(
    parameter int DATA_WIDTH     = 36,
    parameter int LANE_WIDTH     = 9,
    parameter int DEPTH          = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int MODE_A         = 0,
    parameter int MODE_B         = 0,
    parameter int CLEAR_ON_RESET = 1,
    localparam int NUM_LANES     = DATA_WIDTH / LANE_WIDTH,
    localparam int ADDR_WIDTH    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_portA_en,
    input  logic [NUM_LANES-1:0]  io_portA_writeEn,
    input  logic [ADDR_WIDTH-1:0] io_portA_addr,
    input  logic [DATA_WIDTH-1:0] io_portA_dataIn,
    output logic [DATA_WIDTH-1:0] io_portA_dataOut,
    output logic                  io_portA_valid,
    input  logic                  io_portB_en,
    input  logic [NUM_LANES-1:0]  io_portB_writeEn,
    input  logic [ADDR_WIDTH-1:0] io_portB_addr,
    input  logic [DATA_WIDTH-1:0] io_portB_dataIn,
    output logic [DATA_WIDTH-1:0] io_portB_dataOut,
    output logic                  io_portB_valid,
    output logic                  io_busy,
    output logic                  io_collision
);

    typedef enum logic {CLEAR, IDLE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
    logic                  clr_we;
    logic                  coll_q;

    logic                  en      [2];
    logic [NUM_LANES-1:0]  we      [2];
    logic [ADDR_WIDTH-1:0] addr    [2];
    logic [DATA_WIDTH-1:0] din     [2];
    logic                  acc_v   [2];
    logic                  wr_any  [2];
    logic                  wr_en   [2];
    logic                  out_vld [2];
    logic [DATA_WIDTH-1:0] out_dat [2];

    assign en[0]   = io_portA_en;
    assign we[0]   = io_portA_writeEn;
    assign addr[0] = io_portA_addr;
    assign din[0]  = io_portA_dataIn;
    assign en[1]   = io_portB_en;
    assign we[1]   = io_portB_writeEn;
    assign addr[1] = io_portB_addr;
    assign din[1]  = io_portB_dataIn;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            CLEAR: begin
                clr_we      = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt = IDLE;
                end
            end
            default: ;
        endcase
    end

    assign io_busy = reset || (state == CLEAR);

    for (genvar p = 0; p < 2; p++) begin : g_port
        localparam int MODE = (p == 0) ? MODE_A : MODE_B;

        logic                  is_wr, in_rng, rd_upd, s1_vld;
        logic [DATA_WIDTH-1:0] lane_mask, s1_dat;

        assign acc_v[p]  = en[p] && !io_busy;
        assign is_wr     = |we[p];
        assign in_rng    = 32'(addr[p]) < 32'(DEPTH);
        assign wr_any[p] = is_wr;
        assign wr_en[p]  = acc_v[p] && is_wr && in_rng;
        // NO_CHANGE writes leave the read pipeline untouched
        assign rd_upd    = acc_v[p] && !(is_wr && MODE == 2);

        always_comb begin
            lane_mask = '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_mask[i*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{we[p][i]}};
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                s1_vld <= 1'b0;
                s1_dat <= '0;
            end else begin
                s1_vld <= rd_upd;
                if (rd_upd) begin
                    if (!in_rng) begin
                        s1_dat <= '0;
                    end else if (MODE == 1 && is_wr) begin
                        s1_dat <= (mem[addr[p]] & ~lane_mask) | (din[p] & lane_mask);
                    end else begin
                        s1_dat <= mem[addr[p]];
                    end
                end
            end
        end

        if (READ_LATENCY == 2) begin : g_lat2
            logic                  s2_vld;
            logic [DATA_WIDTH-1:0] s2_dat;

            always_ff @(posedge clock) begin
                if (reset) begin
                    s2_vld <= 1'b0;
                    s2_dat <= '0;
                end else begin
                    s2_vld <= s1_vld;
                    if (s1_vld) begin
                        s2_dat <= s1_dat;
                    end
                end
            end

            assign out_vld[p] = s2_vld;
            assign out_dat[p] = s2_dat;
        end else begin : g_lat1
            assign out_vld[p] = s1_vld;
            assign out_dat[p] = s1_dat;
        end
    end

    // Port B lanes are written first so overlapping port A lanes take precedence.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (clr_we) begin
                mem[clr_cnt] <= '0;
            end else begin
                for (int p = 1; p >= 0; p--) begin
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (wr_en[p] && we[p][i]) begin
                            mem[addr[p]][i*LANE_WIDTH +: LANE_WIDTH] <= din[p][i*LANE_WIDTH +: LANE_WIDTH];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= acc_v[0] && acc_v[1] && (addr[0] == addr[1]) && (wr_any[0] || wr_any[1]);
        end
    end

    assign io_collision     = coll_q;
    assign io_portA_dataOut = out_dat[0];
    assign io_portA_valid   = out_vld[0];
    assign io_portB_dataOut = out_dat[1];
    assign io_portB_valid   = out_vld[1];

endmodule

// File: tb/tb_bram_tdp_pipelined.sv
// Three RAM configurations driven with identical stimulus; a behavioural model queues expected
// read results per port and the negedge checker pops and compares them as the DUTs produce output.
module tb_bram_tdp_pipelined;

    localparam int ND = 3;

    logic clock = 1'b0;
    logic reset;
    logic en_a, en_b;
    logic [3:0] we_a, we_b, addr_a, addr_b;
    logic [35:0] din_a, din_b;
    logic [ND-1:0][35:0] dout_a, dout_b;
    logic [ND-1:0] vld_a, vld_b, busy, coll;

    always #5 clock = ~clock;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        bram_tdp_pipelined #(
            .DATA_WIDTH(36),
            .LANE_WIDTH(9),
            .DEPTH(g == 1 ? 12 : 16),
            .READ_LATENCY(g == 0 ? 2 : 1),
            .MODE_A(g == 0 ? 0 : (g == 1 ? 2 : 1)),
            .MODE_B(g == 0 ? 1 : (g == 1 ? 0 : 2)),
            .CLEAR_ON_RESET(g == 1 ? 0 : 1)
        ) u_dut (
            .clock(clock),
            .reset(reset),
            .io_portA_en(en_a),
            .io_portA_writeEn(we_a),
            .io_portA_addr(addr_a),
            .io_portA_dataIn(din_a),
            .io_portA_dataOut(dout_a[g]),
            .io_portA_valid(vld_a[g]),
            .io_portB_en(en_b),
            .io_portB_writeEn(we_b),
            .io_portB_addr(addr_b),
            .io_portB_dataIn(din_b),
            .io_portB_dataOut(dout_b[g]),
            .io_portB_valid(vld_b[g]),
            .io_busy(busy[g]),
            .io_collision(coll[g])
        );
    end

    function automatic int p_depth(input int d);
        return (d == 1) ? 12 : 16;
    endfunction
    function automatic int p_lat(input int d);
        return (d == 0) ? 2 : 1;
    endfunction
    function automatic int p_clr(input int d);
        return (d == 1) ? 0 : 1;
    endfunction
    function automatic int p_mode(input int d, input int p);
        case (d)
            0:       return (p == 0) ? 0 : 1;
            1:       return (p == 0) ? 2 : 0;
            default: return (p == 0) ? 1 : 2;
        endcase
    endfunction
    function automatic logic [35:0] lm(input logic [3:0] w);
        logic [35:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (w[i]) m[i*9 +: 9] = 9'h1FF;
        return m;
    endfunction

    typedef struct {
        int          cyc;
        logic [35:0] dat;
        logic [35:0] km;
    } exp_t;

    logic [35:0] mm [ND][16];
    logic [35:0] mk [ND][16];
    int          bl [ND];
    exp_t        q  [ND*2][$];
    int          cq [ND][$];
    logic [35:0] last_d [ND*2];
    logic [35:0] last_k [ND*2];
    int          cyc, n_cmp, n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic r,
                        input logic ea, input logic [3:0] wa, input logic [3:0] aa, input logic [35:0] da,
                        input logic eb, input logic [3:0] wb, input logic [3:0] ab, input logic [35:0] db);
        logic        ev [2];
        logic [3:0]  w  [2];
        logic [3:0]  a  [2];
        logic [35:0] dd [2];
        logic        acc [ND][2];
        reset = r;
        en_a = ea; we_a = wa; addr_a = aa; din_a = da;
        en_b = eb; we_b = wb; addr_b = ab; din_b = db;
        ev[0] = ea; w[0] = wa; a[0] = aa; dd[0] = da;
        ev[1] = eb; w[1] = wb; a[1] = ab; dd[1] = db;

        for (int d = 0; d < ND; d++) begin
            logic bz;
            bz = r || (bl[d] > 0);
            for (int p = 0; p < 2; p++) begin
                exp_t x;
                acc[d][p] = ev[p] && !bz;
                if (acc[d][p] && !((w[p] != 4'h0) && p_mode(d, p) == 2)) begin
                    x.cyc = cyc + p_lat(d);
                    if (int'(a[p]) >= p_depth(d)) begin
                        x.dat = '0;
                        x.km  = '1;
                    end else if ((w[p] != 4'h0) && p_mode(d, p) == 1) begin
                        x.dat = (mm[d][a[p]] & ~lm(w[p])) | (dd[p] & lm(w[p]));
                        x.km  = mk[d][a[p]] | lm(w[p]);
                    end else begin
                        x.dat = mm[d][a[p]];
                        x.km  = mk[d][a[p]];
                    end
                    q[d*2+p].push_back(x);
                end
            end
            if (acc[d][0] && acc[d][1] && a[0] == a[1] && (w[0] != 4'h0 || w[1] != 4'h0))
                cq[d].push_back(cyc + 1);
        end

        @(negedge clock);
        for (int d = 0; d < ND; d++) begin
            logic ec;
            chk($sformatf("d%0d busy", d), 64'(busy[d]), 64'(r || bl[d] > 0));
            for (int p = 0; p < 2; p++) begin
                int          i;
                logic        xv, ov;
                logic [35:0] od;
                exp_t        x;
                i  = d*2 + p;
                xv = 1'b0;
                ov = (p == 0) ? vld_a[d] : vld_b[d];
                od = (p == 0) ? dout_a[d] : dout_b[d];
                if (q[i].size() > 0 && q[i][0].cyc == cyc) begin
                    x = q[i].pop_front();
                    xv = 1'b1;
                    last_d[i] = x.dat;
                    last_k[i] = x.km;
                end
                chk($sformatf("d%0d p%0d valid", d, p), 64'(ov), 64'(xv));
                chk($sformatf("d%0d p%0d dataOut", d, p), 64'(od & last_k[i]), 64'(last_d[i] & last_k[i]));
            end
            ec = 1'b0;
            if (cq[d].size() > 0 && cq[d][0] == cyc) begin
                void'(cq[d].pop_front());
                ec = 1'b1;
            end
            chk($sformatf("d%0d collision", d), 64'(coll[d]), 64'(ec));

            if (r) begin
                for (int p = 0; p < 2; p++) begin
                    q[d*2+p].delete();
                    last_d[d*2+p] = '0;
                    last_k[d*2+p] = '1;
                end
                cq[d].delete();
                bl[d] = (p_clr(d) != 0) ? p_depth(d) : 0;
            end else if (bl[d] > 0) begin
                mm[d][p_depth(d) - bl[d]] = '0;
                mk[d][p_depth(d) - bl[d]] = '1;
                bl[d]--;
            end else begin
                for (int p = 1; p >= 0; p--) begin
                    if (acc[d][p] && w[p] != 4'h0 && int'(a[p]) < p_depth(d)) begin
                        mm[d][a[p]] = (mm[d][a[p]] & ~lm(w[p])) | (dd[p] & lm(w[p]));
                        mk[d][a[p]] = mk[d][a[p]] | lm(w[p]);
                    end
                end
            end
        end
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic idle(input logic r, input int n);
        repeat (n) step(r, 1'b0, 4'h0, 4'h0, 36'h0, 1'b0, 4'h0, 4'h0, 36'h0);
    endtask

    initial begin
        logic [35:0] rv;
        cyc = 0; n_cmp = 0; n_err = 0;
        reset = 1'b1;
        en_a = 1'b0; we_a = '0; addr_a = '0; din_a = '0;
        en_b = 1'b0; we_b = '0; addr_b = '0; din_b = '0;
        for (int d = 0; d < ND; d++) begin
            bl[d] = 0;
            for (int k = 0; k < 16; k++) begin
                mm[d][k] = '0;
                mk[d][k] = '0;
            end
        end
        for (int i = 0; i < ND*2; i++) begin
            last_d[i] = '0;
            last_k[i] = '1;
        end
        @(posedge clock);
        #1;

        // Reset, then accesses issued while the clear sequencer runs
        idle(1'b1, 2);
        idle(1'b0, 3);
        step(1'b0, 1'b1, 4'hF, 4'h2, 36'h5A5A5A5A5, 1'b1, 4'h0, 4'h2, 36'h0);
        step(1'b0, 1'b1, 4'h0, 4'h2, 36'h0, 1'b1, 4'hF, 4'h6, 36'h0F0F0F0F0);
        idle(1'b0, 16);
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 4'h0, 4'(i), 36'h0, 1'b1, 4'h0, 4'(15 - i), 36'h0);

        // Preload random words, reset, then reset again with the clear counter at 7
        for (int i = 0; i < 16; i++) begin
            rv = 36'({$urandom(), $urandom()});
            step(1'b0, 1'b1, 4'hF, 4'(i), rv, 1'b0, 4'h0, 4'h0, 36'h0);
        end
        idle(1'b1, 3);
        idle(1'b0, 7);
        idle(1'b1, 1);
        idle(1'b0, 17);
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b1, 4'h0, 4'(i), 36'h0, 1'b1, 4'h0, 4'(i), 36'h0);

        // Latency and back-to-back throughput
        step(1'b0, 1'b1, 4'hF, 4'h5, 36'h123456789, 1'b0, 4'h0, 4'h0, 36'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 36'h0, 1'b1, 4'h0, 4'h5, 36'h0);
        for (int i = 4; i < 7; i++)
            step(1'b0, 1'b0, 4'h0, 4'h0, 36'h0, 1'b1, 4'h0, 4'(i), 36'h0);
        idle(1'b0, 2);

        // Lane writes
        step(1'b0, 1'b1, 4'hF, 4'h7, 36'hFFFFFFFFF, 1'b0, 4'h0, 4'h0, 36'h0);
        step(1'b0, 1'b1, 4'b0101, 4'h7, 36'h000000000, 1'b0, 4'h0, 4'h0, 36'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0, 36'h0, 1'b1, 4'h0, 4'h7, 36'h0);
        idle(1'b0, 2);

        // Read-during-write modes, full and partial
        step(1'b0, 1'b1, 4'hF, 4'h3, 36'hAAA, 1'b1, 4'hF, 4'hB, 36'hDDDDDDDDD);
        step(1'b0, 1'b1, 4'hF, 4'h3, 36'hBBB, 1'b1, 4'b0011, 4'hB, 36'h000000CCC);
        step(1'b0, 1'b1, 4'h0, 4'h3, 36'h0, 1'b1, 4'h0, 4'hB, 36'h0);
        idle(1'b0, 2);

        // Cross-port conflicts
        step(1'b0, 1'b1, 4'hF, 4'h9, 36'h111, 1'b1, 4'hF, 4'h9, 36'h222);
        step(1'b0, 1'b1, 4'h0, 4'h9, 36'h0, 1'b1, 4'hF, 4'h9, 36'h333);
        step(1'b0, 1'b0, 4'h0, 4'h0, 36'h0, 1'b1, 4'h0, 4'h9, 36'h0);
        step(1'b0, 1'b1, 4'b0011, 4'h8, 36'hAAAAAAAAA, 1'b1, 4'b0110, 4'h8, 36'h555555555);
        step(1'b0, 1'b1, 4'h0, 4'h8, 36'h0, 1'b1, 4'h0, 4'h8, 36'h0);
        idle(1'b0, 2);

        // Addresses beyond DEPTH on the 12-word instance
        step(1'b0, 1'b1, 4'hF, 4'hD, 36'hEEE, 1'b1, 4'h0, 4'hD, 36'h0);
        step(1'b0, 1'b1, 4'h0, 4'hD, 36'h0, 1'b1, 4'h0, 4'hC, 36'h0);
        idle(1'b0, 2);

        // Random traffic
        repeat (80) begin
            logic [3:0] wa, wb;
            wa = ($urandom_range(1, 0) != 0) ? 4'($urandom_range(15, 0)) : 4'h0;
            wb = ($urandom_range(1, 0) != 0) ? 4'($urandom_range(15, 0)) : 4'h0;
            step(1'b0,
                 1'($urandom_range(1, 0)), wa, 4'($urandom_range(15, 0)), 36'({$urandom(), $urandom()}),
                 1'($urandom_range(1, 0)), wb, 4'($urandom_range(15, 0)), 36'({$urandom(), $urandom()}));
        end
        idle(1'b0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
